cirno9_sram_arb: RTL and testbench

- Arbitrates the core's single SRAM port between three requesters: index 0 = instruction fetch, 1 = load/store unit, 2 = external slave (AXI-slave path).
- Registers the winning command onto the SRAM strobes and returns read data or a write ack to the granted requester.
- Sits between the fetch/LSU datapath and the SRAM macro, replacing ad-hoc muxing inside the LSU.

---
 rtl/cirno9_sram_arb_if.sv | 35 +++
 rtl/cirno9_sram_arb.sv | 197 +++++++++++++++++++
 tb/tb_cirno9_sram_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cirno9_sram_arb_if.sv
// cirno9_sram_arb_if
// Requester-side bundle of the SRAM arbiter. Bit/slice i of every packed
// field belongs to requester i (0 = fetch, 1 = LSU, 2 = external slave).
//   i_req_val   request valid per requester
//   o_req_rdy   request accepted (one-hot or zero)
//   i_req_adr   packed byte addresses, requester i at [i*AW +: AW]
//   i_req_wdat  packed write data, 32 bits per requester
//   i_req_wen   packed byte write enables, 4 bits per requester
//   i_req_ren   read enable per requester
//   o_rsp_val   one-cycle response pulse (one-hot or zero)
//   o_rsp_rdat  read data qualified by o_rsp_val
// master = requester side, slave = arbiter side.
interface cirno9_sram_arb_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 32
);
  logic [N_REQ-1:0]    i_req_val;
  logic [N_REQ-1:0]    o_req_rdy;
  logic [N_REQ*AW-1:0] i_req_adr;
  logic [N_REQ*32-1:0] i_req_wdat;
  logic [N_REQ*4-1:0]  i_req_wen;
  logic [N_REQ-1:0]    i_req_ren;
  logic [N_REQ-1:0]    o_rsp_val;
  logic [31:0]         o_rsp_rdat;

  modport master (
    output i_req_val, i_req_adr, i_req_wdat, i_req_wen, i_req_ren,
    input  o_req_rdy, o_rsp_val, o_rsp_rdat
  );

  modport slave (
    input  i_req_val, i_req_adr, i_req_wdat, i_req_wen, i_req_ren,
    output o_req_rdy, o_rsp_val, o_rsp_rdat
  );
endinterface

// File: rtl/cirno9_sram_arb.sv
// cirno9_sram_arb
// Shares the single SRAM port between N_REQ requesters. A winning request is
// registered, driven onto the SRAM strobes for one cycle (CMD), and answered
// with a one-cycle response pulse (RSP). A new request may be accepted in
// IDLE or in RSP, giving one access every two cycles at best.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   bus           requester bundle (cirno9_sram_arb_if.slave)
//   o_sram_ren    SRAM read strobe (CMD only)
//   o_sram_wen    SRAM byte write strobes (CMD only)
//   o_sram_adr    SRAM address, holds last value outside CMD
//   o_sram_wdat   SRAM write data, holds last value outside CMD
//   i_sram_rdat   SRAM read data, valid one cycle after o_sram_ren
//   o_busy        high in CMD or RSP
//
// Build option: define CIRNO9_ARB_RR_EN to replace fixed priority
// (1 > 0 > 2) with starvation override by a round-robin arbiter.
module cirno9_sram_arb #(
  parameter int N_REQ      = 3,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cirno9_sram_arb_if.slave     bus,
  output logic                 o_sram_ren,
  output logic [3:0]           o_sram_wen,
  output logic [AW-1:0]        o_sram_adr,
  output logic [31:0]          o_sram_wdat,
  input  logic [31:0]          i_sram_rdat,
  output logic                 o_busy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic            rd_q, rd_d;
  logic            sram_ren_q, sram_ren_d;
  logic [3:0]      sram_wen_q, sram_wen_d;
  logic [AW-1:0]   sram_adr_q, sram_adr_d;
  logic [31:0]     sram_wdat_q, sram_wdat_d;

  logic            accept;
  logic [GW-1:0]   win;
  logic [3:0]      win_wen;
  logic            win_ren;

`ifdef CIRNO9_ARB_RR_EN
  logic [GW-1:0]   ptr_q, ptr_d;

  // Search starts one past the last grant, so the last winner is tried last.
  function automatic logic [GW-1:0] pick_rr(input logic [N_REQ-1:0] val,
                                            input logic [GW-1:0]    ptr);
    logic [GW-1:0] sel;
    sel = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (val[(int'(ptr) + k) % N_REQ]) sel = GW'((int'(ptr) + k) % N_REQ);
    end
    return sel;
  endfunction

  always_comb begin
    win = pick_rr(bus.i_req_val, ptr_q);
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]    cnt_q [N_REQ];
  logic [CW-1:0]    cnt_d [N_REQ];
  logic [N_REQ-1:0] starved;

  // Starved requesters win first (lowest index among them); otherwise the
  // LSU goes first and the rest fall back to lowest index.
  function automatic logic [GW-1:0] pick_fixed(input logic [N_REQ-1:0] val,
                                               input logic [N_REQ-1:0] stv);
    logic [GW-1:0] sel;
    sel = '0;
    if (|stv) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (stv[i]) sel = GW'(i);
      end
    end else if (val[1]) begin
      sel = GW'(1);
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (val[i]) sel = GW'(i);
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      starved[i] = bus.i_req_val[i] && (cnt_q[i] == CW'(STARVE_MAX));
    end
    win = pick_fixed(bus.i_req_val, starved);
  end

  // A waiting requester that loses an accept ages by one; winning or
  // dropping val resets its age.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!bus.i_req_val[i]) begin
        cnt_d[i] = '0;
      end else if (accept) begin
        if (GW'(i) == win) cnt_d[i] = '0;
        else if (cnt_q[i] != CW'(STARVE_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
`endif

  // Accept only while the SRAM port is free for a new command next cycle;
  // rdy is held low during reset so nothing is accepted then.
  assign accept  = ((state_q == IDLE) || (state_q == RSP)) && (|bus.i_req_val) && !rst;
  assign win_wen = bus.i_req_wen[int'(win)*4 +: 4];
  assign win_ren = bus.i_req_ren[win];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rd_d        = rd_q;
    sram_ren_d  = 1'b0;
    sram_wen_d  = 4'h0;
    sram_adr_d  = sram_adr_q;
    sram_wdat_d = sram_wdat_q;

    case (state_q)
      IDLE:    state_d = accept ? CMD : IDLE;
      CMD:     state_d = RSP;
      RSP:     state_d = accept ? CMD : IDLE;
      default: state_d = IDLE;
    endcase

    // Any write enable makes it a write; no enables at all is a no-op that
    // still returns a response but never strobes the SRAM.
    if (accept) begin
      gnt_d       = win;
      rd_d        = (win_wen == 4'h0) && win_ren;
      sram_ren_d  = (win_wen == 4'h0) && win_ren;
      sram_wen_d  = win_wen;
      sram_adr_d  = bus.i_req_adr[int'(win)*AW +: AW];
      sram_wdat_d = bus.i_req_wdat[int'(win)*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rd_q        <= 1'b0;
      sram_ren_q  <= 1'b0;
      sram_wen_q  <= 4'h0;
      sram_adr_q  <= '0;
      sram_wdat_q <= '0;
`ifdef CIRNO9_ARB_RR_EN
      ptr_q       <= '0;
`else
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rd_q        <= rd_d;
      sram_ren_q  <= sram_ren_d;
      sram_wen_q  <= sram_wen_d;
      sram_adr_q  <= sram_adr_d;
      sram_wdat_q <= sram_wdat_d;
`ifdef CIRNO9_ARB_RR_EN
      ptr_q       <= ptr_d;
`else
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

`ifdef CIRNO9_ARB_RR_EN
  assign ptr_d = accept ? win : ptr_q;
`endif

  assign bus.o_req_rdy  = accept ? (N_REQ'(1) << win) : '0;
  // Read data is passed straight through since the macro returns it in RSP.
  assign bus.o_rsp_val  = (state_q == RSP) ? (N_REQ'(1) << gnt_q) : '0;
  assign bus.o_rsp_rdat = ((state_q == RSP) && rd_q) ? i_sram_rdat : 32'h0;

  assign o_sram_ren  = sram_ren_q;
  assign o_sram_wen  = sram_wen_q;
  assign o_sram_adr  = sram_adr_q;
  assign o_sram_wdat = sram_wdat_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cirno9_sram_arb.sv
// tb_cirno9_sram_arb
// Self-checking bench for cirno9_sram_arb: directed vector table, corner
// sequences (starvation / round-robin order, reset mid-command) and a
// randomized run against a transaction-level reference model.
module tb_cirno9_sram_arb;
  localparam int N_REQ      = 3;
  localparam int AW         = 32;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sram_ren;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_wdat;
  logic [31:0]   sram_rdat;
  logic          busy;

  int total = 0;
  int bad   = 0;

  cirno9_sram_arb_if #(.N_REQ(N_REQ), .AW(AW)) bus ();

  cirno9_sram_arb #(.N_REQ(N_REQ), .STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_sram_ren  (sram_ren),
    .o_sram_wen  (sram_wen),
    .o_sram_adr  (sram_adr),
    .o_sram_wdat (sram_wdat),
    .i_sram_rdat (sram_rdat),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic        ren;
    logic [31:0] srdat;
    logic        exp_ren;
    logic [3:0]  exp_wen;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.i_req_val  = '0;
    bus.i_req_adr  = '0;
    bus.i_req_wdat = '0;
    bus.i_req_wen  = '0;
    bus.i_req_ren  = '0;
  endtask

  task automatic setReq(input int i, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] wen, input logic ren);
    bus.i_req_val[i]             = 1'b1;
    bus.i_req_adr[i*AW +: AW]    = adr;
    bus.i_req_wdat[i*32 +: 32]   = wdat;
    bus.i_req_wen[i*4 +: 4]      = wen;
    bus.i_req_ren[i]             = ren;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    step();
  endtask

  // One isolated transaction from IDLE: accept at T, strobe at T+1, rsp at T+2.
  task automatic applyStimulus(input int n, input vec_t v);
    clearInputs();
    setReq(v.idx, v.adr, v.wdat, v.wen, v.ren);
    sram_rdat = v.srdat;
    #1;
    checkOutput($sformatf("v%0d_rdy", n), bus.o_req_rdy, 3'b001 << v.idx);
    checkOutput($sformatf("v%0d_busy_t0", n), busy, 0);
    step();
    clearInputs();
    #1;
    checkOutput($sformatf("v%0d_sram_ren", n), sram_ren, v.exp_ren);
    checkOutput($sformatf("v%0d_sram_wen", n), sram_wen, v.exp_wen);
    checkOutput($sformatf("v%0d_sram_adr", n), sram_adr, v.adr);
    checkOutput($sformatf("v%0d_sram_wdat", n), sram_wdat, v.wdat);
    checkOutput($sformatf("v%0d_busy_t1", n), busy, 1);
    checkOutput($sformatf("v%0d_rsp_t1", n), bus.o_rsp_val, 0);
    step();
    checkOutput($sformatf("v%0d_rsp_val", n), bus.o_rsp_val, 3'b001 << v.idx);
    checkOutput($sformatf("v%0d_rsp_rdat", n), bus.o_rsp_rdat, v.exp_rdat);
    checkOutput($sformatf("v%0d_strobe_off", n), {sram_ren, sram_wen}, 0);
    checkOutput($sformatf("v%0d_busy_t2", n), busy, 1);
    step();
    checkOutput($sformatf("v%0d_rsp_t3", n), bus.o_rsp_val, 0);
    checkOutput($sformatf("v%0d_busy_t3", n), busy, 0);
  endtask

  // Holds the given requesters valid and checks the sequence of grants and
  // the two-cycle spacing between them.
  task automatic grantOrder(input string tag, input logic [2:0] reqs, input int n,
                            input logic [2:0] exp [6]);
    int last = 0;
    int cyc  = 0;
    int k    = 0;
    clearInputs();
    for (int i = 0; i < N_REQ; i++) begin
      if (reqs[i]) setReq(i, 32'h10 * (i + 1), 32'h0, 4'h0, 1'b1);
    end
    while (k < n && cyc < 40) begin
      #1;
      if (bus.o_req_rdy != 0) begin
        checkOutput($sformatf("%s_grant%0d", tag, k), bus.o_req_rdy, exp[k]);
        if (k > 0) checkOutput($sformatf("%s_gap%0d", tag, k), cyc - last, 2);
        last = cyc;
        k++;
      end
      step();
      cyc++;
    end
    if (k < n) checkOutput($sformatf("%s_timeout", tag), k, n);
    clearInputs();
    repeat (3) step();
  endtask

  function automatic int modelPick(input logic [N_REQ-1:0] val, input int cnt [N_REQ], input int ptr);
`ifdef CIRNO9_ARB_RR_EN
    for (int k = 1; k <= N_REQ; k++) begin
      if (val[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      if (val[i] && cnt[i] >= STARVE_MAX) return i;
    end
    if (val[1]) return 1;
    for (int i = 0; i < N_REQ; i++) begin
      if (val[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Transaction model: an accept is possible in any cycle not directly after
  // another accept; the command shows one cycle later, the response two.
  task automatic runRandom(input int cycles);
    logic             pend   [N_REQ];
    logic [31:0]      p_adr  [N_REQ];
    logic [31:0]      p_wdat [N_REQ];
    logic [3:0]       p_wen  [N_REQ];
    logic             p_ren  [N_REQ];
    int               cnt    [N_REQ];
    logic             s1_v, s2_v, s1_rd, s2_rd;
    int               s1_g, s2_g;
    logic [31:0]      s1_adr, s1_wdat, shown_adr, shown_wdat;
    logic [3:0]       s1_wen;
    logic [N_REQ-1:0] val;
    logic [31:0]      srd;
    int               rr_ptr, win;
    logic             acc;
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0; cnt[i] = 0;
      p_adr[i] = '0; p_wdat[i] = '0; p_wen[i] = '0; p_ren[i] = 1'b0;
    end
    s1_v = 1'b0; s2_v = 1'b0; s1_rd = 1'b0; s2_rd = 1'b0; s1_g = 0; s2_g = 0;
    s1_adr = '0; s1_wdat = '0; s1_wen = '0; shown_adr = '0; shown_wdat = '0;
    rr_ptr = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4) begin
          pend[i]   = 1'b1;
          p_adr[i]  = $urandom;
          p_wdat[i] = $urandom;
          p_wen[i]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          p_ren[i]  = 1'($urandom);
        end
      end
      clearInputs();
      val = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i]) begin
          setReq(i, p_adr[i], p_wdat[i], p_wen[i], p_ren[i]);
          val[i] = 1'b1;
        end
      end
      srd = $urandom;
      sram_rdat = srd;
      #1;
      if (s1_v) begin
        shown_adr  = s1_adr;
        shown_wdat = s1_wdat;
      end
      win = (!s1_v && val != 0) ? modelPick(val, cnt, rr_ptr) : -1;
      acc = (win >= 0);
      checkOutput("rnd_rdy", bus.o_req_rdy, acc ? (3'b001 << win) : 3'b000);
      checkOutput("rnd_sram_ren", sram_ren, s1_v && s1_rd);
      checkOutput("rnd_sram_wen", sram_wen, s1_v ? s1_wen : 4'h0);
      checkOutput("rnd_sram_adr", sram_adr, shown_adr);
      checkOutput("rnd_sram_wdat", sram_wdat, shown_wdat);
      checkOutput("rnd_rsp_val", bus.o_rsp_val, s2_v ? (3'b001 << s2_g) : 3'b000);
      checkOutput("rnd_rsp_rdat", bus.o_rsp_rdat, (s2_v && s2_rd) ? srd : 32'h0);
      checkOutput("rnd_busy", busy, s1_v || s2_v);
      for (int i = 0; i < N_REQ; i++) begin
        if (!val[i]) cnt[i] = 0;
        else if (acc) begin
          if (i == win) cnt[i] = 0;
          else if (cnt[i] < STARVE_MAX) cnt[i]++;
        end
      end
      s2_v = s1_v; s2_g = s1_g; s2_rd = s1_rd;
      s1_v = acc;
      if (acc) begin
        s1_g    = win;
        s1_rd   = (p_wen[win] == 4'h0) && p_ren[win];
        s1_adr  = p_adr[win];
        s1_wdat = p_wdat[win];
        s1_wen  = p_wen[win];
        pend[win] = 1'b0;
        rr_ptr  = win;
      end
      step();
    end
    clearInputs();
    repeat (3) step();
  endtask

  initial begin
    logic [2:0] order [6];
    vecs[0] = '{0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 32'h0000_0040, 32'h1234_5678, 4'h3, 1'b1, 32'hCAFE_F00D, 1'b0, 4'h3, 32'h0000_0000};
    vecs[2] = '{2, 32'h0000_0200, 32'h0BAD_0BAD, 4'h0, 1'b0, 32'h55AA_55AA, 1'b0, 4'h0, 32'h0000_0000};
    vecs[3] = '{2, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1'b1, 32'h0123_4567, 1'b1, 4'h0, 32'h0123_4567};
    vecs[4] = '{0, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h7777_7777, 1'b0, 4'hF, 32'h0000_0000};

    clearInputs();
    sram_rdat = 32'h0;
    rst = 1'b1;
    #3;
    setReq(1, 32'h44, 32'h0, 4'h0, 1'b1);
    #1;
    checkOutput("rst_rdy", bus.o_req_rdy, 0);
    checkOutput("rst_rsp_val", bus.o_rsp_val, 0);
    checkOutput("rst_rsp_rdat", bus.o_rsp_rdat, 0);
    checkOutput("rst_sram_ren", sram_ren, 0);
    checkOutput("rst_sram_wen", sram_wen, 0);
    checkOutput("rst_sram_adr", sram_adr, 0);
    checkOutput("rst_sram_wdat", sram_wdat, 0);
    checkOutput("rst_busy", busy, 0);
    clearInputs();
    step();
    rst = 1'b0;
    step();

    for (int n = 0; n < 5; n++) applyStimulus(n, vecs[n]);

`ifndef CIRNO9_ARB_RR_EN
    order = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
    grantOrder("starve", 3'b011, 5, order);
`endif

    // Reset while the command is on the SRAM strobes.
    clearInputs();
    setReq(0, 32'h300, 32'h0, 4'h0, 1'b1);
    #1;
    step();
    clearInputs();
    #1;
    checkOutput("rstmid_cmd_ren", sram_ren, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_ren", sram_ren, 0);
    checkOutput("rstmid_adr", sram_adr, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_rsp", bus.o_rsp_val, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("rstmid_norsp%0d", c), bus.o_rsp_val, 0);
      step();
    end
    applyStimulus(9, vecs[0]);

`ifdef CIRNO9_ARB_RR_EN
    doReset();
    order = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    grantOrder("rr", 3'b111, 6, order);
`endif

    doReset();
    runRandom(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
